// File: rtl/prirv32_fetch_ctrl.sv
// prirv32_fetch_ctrl: instruction fetch controller.
// Issues one word-aligned read at a time to instruction memory and holds the
// returned word for the decoder until it is consumed or a redirect arrives.
// A redirect that lands while a read is outstanding waits for that read to
// finish (DRAIN), throws its data away, and then fetches from the new target.
module prirv32_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        misalign_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retire_q, retire_d;
    logic        misalign_q, misalign_d;
    logic [31:0] redirTarget;

    // Redirect targets are forced onto a word boundary; the low bits only
    // feed the misalignment flag.
    assign redirTarget = {redirect_pc_i[31:2], 2'b00};

    // Next-state and datapath decisions for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        misalign_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);
        retire_d   = retire_q;

        if ((state_q == HOLD) && instr_ready_i && !redirect_i) begin
            retire_d = retire_q + 32'd1;
        end

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_i) begin
                        fetch_pc_d = redirTarget;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = HOLD;
                    end
                end else if (redirect_i) begin
                    target_d = redirTarget;
                    state_d  = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    fetch_pc_d = redirTarget;
                    state_d    = FETCH;
                end else if (instr_ready_i) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_i) begin
                    target_d = redirTarget;
                end
                if (imem_ack) begin
                    fetch_pc_d = redirect_i ? redirTarget : target_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            target_q   <= 32'h0000_0000;
            instr_q    <= 32'h0000_0000;
            pc_q       <= 32'h0000_0000;
            retire_q   <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            retire_q   <= retire_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req      = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr     = fetch_pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = (state_q == HOLD);
    assign misalign_o    = misalign_q;
    assign retire_cnt_o  = retire_q;

endmodule

// File: doc/prirv32_fetch_ctrl.md
PRIRV32_FETCH_CTRL -- requirements
Module: prirv32_fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide port clk_in  input  1  clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL provide port imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL provide port imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-007 SHALL provide port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL provide port instr_o  output  32  held instruction word for the decoder.
REQ-009 SHALL provide port pc_o  output  32  address of instr_o.
REQ-010 SHALL provide port instr_valid_o  output  1  instr_o/pc_o valid.
REQ-011 SHALL provide port instr_ready_i  input  1  decoder consumes instr_o when valid and ready.
REQ-012 SHALL provide port redirect_i  input  1  one-cycle branch/jump/trap redirect request.
REQ-013 SHALL provide port redirect_pc_i  input  32  redirect target.
REQ-014 SHALL provide port misalign_o  output  1  one-cycle pulse: redirect target had [1:0] != 0.
REQ-015 SHALL provide port retire_cnt_o  output  32  count of valid/ready handshakes.

Function
REQ-016 SHALL implement states BOOT, FETCH, HOLD, DRAIN; BOOT lasts exactly one cycle after rst_n deasserts, then FETCH with fetch_pc = RESET_PC.
REQ-017 SHALL drive imem_req = 1 only in FETCH and DRAIN; imem_addr SHALL equal the outstanding address and stay stable until imem_ack.
REQ-018 FETCH, imem_ack, no redirect: SHALL latch instr_o = imem_rdata and pc_o = fetch_pc, set fetch_pc += 4 (mod 2^32 wrap), go HOLD.
REQ-019 FETCH, imem_ack and redirect_i same cycle: SHALL discard data, set fetch_pc = target, stay FETCH (new request next cycle).
REQ-020 FETCH, redirect_i without imem_ack: SHALL store target, go DRAIN.
REQ-021 DRAIN: SHALL keep the old request until imem_ack, discard its data, then go FETCH with the stored target; a later redirect in DRAIN SHALL overwrite the stored target (last wins).
REQ-022 HOLD: instr_valid_o = 1; instr_ready_i SHALL move to FETCH next cycle; instr_o/pc_o SHALL stay stable while not consumed.
REQ-023 HOLD, redirect_i: SHALL have priority over instr_ready_i, drop instr_valid_o next cycle, set fetch_pc = target, go FETCH, no handshake counted.
REQ-024 instr_valid_o SHALL be 0 in BOOT, FETCH, DRAIN; latency from imem_ack to instr_valid_o = 1 cycle.
REQ-025 Target = {redirect_pc_i[31:2], 2'b00}; misalign_o SHALL pulse one cycle after a redirect with [1:0] != 0.
REQ-026 retire_cnt_o SHALL increment on each cycle with instr_valid_o & instr_ready_i & !redirect_i, wrapping 32'hFFFF_FFFF -> 0.
REQ-027 imem_ack outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force state BOOT, imem_req = 0, imem_addr = RESET_PC, instr_o = 0, pc_o = 0, instr_valid_o = 0, misalign_o = 0, retire_cnt_o = 0, fetch_pc = RESET_PC, stored target = 0.
REQ-029 Reset mid-request SHALL abandon the outstanding access; the first post-reset request SHALL be to RESET_PC.

Verification
REQ-030 Reset release, imem_ack 1 cycle after each req, ready tied 1 -> addresses 0x0,0x4,0x8; pc_o matches; retire_cnt_o = 3.
REQ-031 Ack delayed 3 cycles -> imem_addr stable at 0x4 for all 4 req cycles; valid exactly 1 cycle after ack.
REQ-032 redirect 0x100 in FETCH before ack -> DRAIN, old data discarded, next request 0x100, no valid for old word.
REQ-033 HOLD with ready=0 for 5 cycles, then redirect and ready together -> valid drops, count unchanged, next fetch at target.
REQ-034 redirect_pc_i = 0x203 -> fetch at 0x200, misalign_o pulses once.
REQ-035 rst_n asserted while req outstanding -> outputs reset at once; after release first imem_addr = RESET_PC; retire_cnt_o preset near 32'hFFFF_FFFF wraps to 0.
